// File: rtl/register_file_sb.sv
// Parametrised register file with two combinational read ports, one write
// port, optional write-through bypass, optional hardwired-zero r0 and a
// per-register busy scoreboard used by the issue stage for hazard checks.
module register_file_sb #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              WEN,
    input  logic [ADDR_W-1:0] RW,
    input  logic [DATA_W-1:0] busW,
    input  logic              RSV,
    input  logic [ADDR_W-1:0] RR,
    input  logic [ADDR_W-1:0] RX,
    input  logic [ADDR_W-1:0] RY,
    output logic [DATA_W-1:0] busX,
    output logic [DATA_W-1:0] busY,
    output logic              busyX,
    output logic              busyY,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic ZERO_EN   = (ZERO_REG != 32'sd0);
    localparam logic BYPASS_EN = (BYPASS != 32'sd0);

    logic [DATA_W-1:0] regs_r [DEPTH];
    logic [DEPTH-1:0]  busy_r;
    logic [DEPTH-1:0]  busy_nxt_s;
    logic [ADDR_W:0]   cnt_nxt_s;
    logic              wr_ok_s;
    logic              rsv_ok_s;

    // True when the address is the hardwired-zero register.
    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
        return ZERO_EN && (addr == {ADDR_W{1'b0}});
    endfunction

    // Operand value seen by a read port, including the write-through path.
    function automatic logic [DATA_W-1:0] read_data(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        if (Rst || is_zero_reg(addr)) begin
            val = {DATA_W{1'b0}};
        end else if (BYPASS_EN && WEN && (RW == addr)) begin
            val = busW;
        end else begin
            val = regs_r[addr];
        end
        return val;
    endfunction

    // Hazard flag seen by a read port; a same-cycle result clears it unless
    // a new producer is reserving the same register in this cycle.
    function automatic logic read_busy(input logic [ADDR_W-1:0] addr);
        logic val;
        if (Rst || is_zero_reg(addr)) begin
            val = 1'b0;
        end else if (BYPASS_EN && WEN && (RW == addr) && !(RSV && (RR == addr))) begin
            val = 1'b0;
        end else begin
            val = busy_r[addr];
        end
        return val;
    endfunction

    // Qualify write and reserve requests against the hardwired-zero register.
    always_comb begin
        wr_ok_s  = WEN && !is_zero_reg(RW);
        rsv_ok_s = RSV && !is_zero_reg(RR);
    end

    // Next scoreboard state: write-back releases, then reserve sets (reserve wins).
    always_comb begin
        busy_nxt_s = busy_r;
        if (wr_ok_s) begin
            busy_nxt_s[RW] = 1'b0;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        if (rsv_ok_s) begin
            busy_nxt_s[RR] = 1'b1;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
    end

    // Population count of the next scoreboard state.
    always_comb begin
        cnt_nxt_s = {(ADDR_W + 1){1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            cnt_nxt_s = cnt_nxt_s + {{ADDR_W{1'b0}}, busy_nxt_s[i]};
        end
    end

    // Register storage: cleared on reset, written from the write-back port.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_ok_s) begin
            regs_r[RW] <= busW;
        end
    end

    // Scoreboard bits and their registered count, updated on the same edge.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            busy_r   <= {DEPTH{1'b0}};
            busy_cnt <= {(ADDR_W + 1){1'b0}};
        end else begin
            busy_r   <= busy_nxt_s;
            busy_cnt <= cnt_nxt_s;
        end
    end

    // Combinational read ports and hazard flags for the issue stage.
    always_comb begin
        busX  = read_data(RX);
        busY  = read_data(RY);
        busyX = read_busy(RX);
        busyY = read_busy(RY);
    end

endmodule

// File: tb/tb_register_file_sb.sv
// Directed self-checking bench for register_file_sb: default 8x8 instance
// plus a 16-bit, 16-entry instance for the parametrised cases.
module tb_register_file_sb;

    logic       Clk;
    logic       Rst;
    logic       WEN, RSV;
    logic [2:0] RW, RR, RX, RY;
    logic [7:0] busW;
    logic [7:0] busX, busY;
    logic       busyX, busyY;
    logic [3:0] busy_cnt;

    logic        b_wen, b_rsv;
    logic [3:0]  b_rw, b_rr, b_rx, b_ry;
    logic [15:0] b_busw;
    logic [15:0] b_busx, b_busy;
    logic        b_busyx, b_busyy;
    logic [4:0]  b_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    register_file_sb dut_a (
        .Clk(Clk), .Rst(Rst), .WEN(WEN), .RW(RW), .busW(busW),
        .RSV(RSV), .RR(RR), .RX(RX), .RY(RY),
        .busX(busX), .busY(busY), .busyX(busyX), .busyY(busyY),
        .busy_cnt(busy_cnt)
    );

    register_file_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1)) dut_b (
        .Clk(Clk), .Rst(Rst), .WEN(b_wen), .RW(b_rw), .busW(b_busw),
        .RSV(b_rsv), .RR(b_rr), .RX(b_rx), .RY(b_ry),
        .busX(b_busx), .busY(b_busy), .busyX(b_busyx), .busyY(b_busyy),
        .busy_cnt(b_cnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Rst = 1'b1; WEN = 1'b0; RSV = 1'b0;
        RW = 3'd0; RR = 3'd0; RX = 3'd0; RY = 3'd0; busW = 8'h00;
        b_wen = 1'b0; b_rsv = 1'b0; b_rw = 4'd0; b_rr = 4'd0;
        b_rx = 4'd0; b_ry = 4'd0; b_busw = 16'h0000;
        #2;
        check_value("reset_busx", 32'(busX), 32'h0);
        check_value("reset_cnt", 32'(busy_cnt), 32'h0);
        tick(); tick();
        #2 Rst = 1'b0;
        tick();

        // Write r6 and read it back, first via bypass then from storage.
        WEN = 1'b1; RW = 3'd6; busW = 8'hAA; RX = 3'd6; RY = 3'd7;
        #1;
        check_value("bypass_busx", 32'(busX), 32'hAA);
        check_value("bypass_busy", 32'(busY), 32'h00);
        tick();
        WEN = 1'b0;
        #1;
        check_value("stored_busx", 32'(busX), 32'hAA);
        check_value("stored_busy", 32'(busY), 32'h00);

        // Write and reserve r0 are both ignored.
        WEN = 1'b1; RW = 3'd0; busW = 8'hFF; RSV = 1'b1; RR = 3'd0; RX = 3'd0;
        tick();
        WEN = 1'b0; RSV = 1'b0;
        #1;
        check_value("r0_busx", 32'(busX), 32'h0);
        check_value("r0_busyx", 32'(busyX), 32'h0);
        check_value("r0_cnt", 32'(busy_cnt), 32'h0);

        // Reserve r3 then r5.
        RSV = 1'b1; RR = 3'd3;
        tick();
        RR = 3'd5;
        tick();
        RSV = 1'b0; RX = 3'd3; RY = 3'd5;
        #1;
        check_value("rsv_cnt2", 32'(busy_cnt), 32'h2);
        check_value("rsv_busyx", 32'(busyX), 32'h1);
        check_value("rsv_busyy", 32'(busyY), 32'h1);

        // Write back r3: flag cleared by bypass now, by storage next cycle.
        WEN = 1'b1; RW = 3'd3; busW = 8'h12;
        #1;
        check_value("wb_bypass_busyx", 32'(busyX), 32'h0);
        check_value("wb_bypass_busx", 32'(busX), 32'h12);
        tick();
        WEN = 1'b0;
        #1;
        check_value("wb_busyx", 32'(busyX), 32'h0);
        check_value("wb_cnt1", 32'(busy_cnt), 32'h1);
        check_value("wb_busx", 32'(busX), 32'h12);

        // Same-address write and reserve: data lands, reserve wins.
        WEN = 1'b1; RW = 3'd4; busW = 8'h55; RSV = 1'b1; RR = 3'd4; RX = 3'd4;
        #1;
        check_value("conf_now_busx", 32'(busX), 32'h55);
        check_value("conf_now_busyx", 32'(busyX), 32'h0);
        tick();
        WEN = 1'b0; RSV = 1'b0;
        #1;
        check_value("conf_busx", 32'(busX), 32'h55);
        check_value("conf_busyx", 32'(busyX), 32'h1);
        check_value("conf_cnt", 32'(busy_cnt), 32'h2);

        // Re-reserving busy r5 leaves the count unchanged.
        RSV = 1'b1; RR = 3'd5;
        tick();
        RSV = 1'b0;
        #1;
        check_value("rersv_cnt", 32'(busy_cnt), 32'h2);

        // Write r5 and reserve r1 in the same cycle.
        WEN = 1'b1; RW = 3'd5; busW = 8'h77; RSV = 1'b1; RR = 3'd1;
        tick();
        WEN = 1'b0; RSV = 1'b0; RX = 3'd1; RY = 3'd5;
        #1;
        check_value("diff_cnt", 32'(busy_cnt), 32'h2);
        check_value("diff_busyx", 32'(busyX), 32'h1);
        check_value("diff_busyy", 32'(busyY), 32'h0);
        check_value("diff_busy", 32'(busY), 32'h77);

        // Asynchronous reset mid-cycle with a write pending.
        WEN = 1'b1; RW = 3'd2; busW = 8'h99; RSV = 1'b1; RR = 3'd6;
        RX = 3'd4; RY = 3'd5;
        #2 Rst = 1'b1;
        #1;
        check_value("arst_busx", 32'(busX), 32'h0);
        check_value("arst_busy", 32'(busY), 32'h0);
        check_value("arst_busyx", 32'(busyX), 32'h0);
        check_value("arst_cnt", 32'(busy_cnt), 32'h0);
        tick();
        WEN = 1'b0; RSV = 1'b0;
        #2 Rst = 1'b0;
        #1;
        check_value("post_rst_r4", 32'(busX), 32'h0);
        check_value("post_rst_r5", 32'(busY), 32'h0);
        RX = 3'd2; RY = 3'd6;
        #1;
        check_value("post_rst_r2", 32'(busX), 32'h0);
        check_value("post_rst_r6", 32'(busY), 32'h0);
        check_value("post_rst_busyy", 32'(busyY), 32'h0);
        tick();

        // Wide/deep instance: r15 read-back and full reservation.
        b_wen = 1'b1; b_rw = 4'd15; b_busw = 16'hBEEF; b_rx = 4'd15;
        tick();
        b_wen = 1'b0;
        #1;
        check_value("wide_busx", 32'(b_busx), 32'hBEEF);
        for (int i = 0; i < 16; i++) begin
            b_rsv = 1'b1; b_rr = 4'(i);
            tick();
        end
        b_rsv = 1'b0; b_rx = 4'd0; b_ry = 4'd15;
        #1;
        check_value("wide_cnt15", 32'(b_cnt), 32'd15);
        check_value("wide_r0_busy", 32'(b_busyx), 32'h0);
        check_value("wide_r15_busy", 32'(b_busyy), 32'h1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
- Parametrised successor to the team's 8x8 two-read/one-write register file.
- Generalised in data width and depth, with optional write-through bypass and a hardwired-zero r0.
- Adds a per-register busy scoreboard: a register is reserved when an instruction issues and released when its result is written back.
- Sits between decode (reserve, reads) and write-back (write) in the team's simple CPU datapath; feeds operands and hazard flags to the issue stage.

Parameters:
- DATA_W, 8, register width in bits.
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers.
- ZERO_REG, 1, 1 = r0 reads 0, ignores writes and is never busy; 0 = r0 is an ordinary register.
- BYPASS, 1, 1 = same-cycle write data is forwarded to the read ports; 0 = reads return stored contents only.

Ports:
- Clk  input  1  clock, all state updates on rising edge.
- Rst  input  1  asynchronous active-high reset.
- WEN  input  1  write enable, active-high.
- RW  input  ADDR_W  write address.
- busW  input  DATA_W  write data.
- RSV  input  1  reserve enable, active-high; marks RR busy.
- RR  input  ADDR_W  reserve address.
- RX  input  ADDR_W  read address X.
- RY  input  ADDR_W  read address Y.
- busX  output  DATA_W  read data X (combinational).
- busY  output  DATA_W  read data Y (combinational).
- busyX  output  1  scoreboard bit of RX (combinational).
- busyY  output  1  scoreboard bit of RY (combinational).
- busy_cnt  output  ADDR_W+1  registered count of busy registers.

Behaviour:
- One clock Clk; reset Rst is asynchronous and active-high. Rst asserted clears all registers, all busy bits and busy_cnt to 0 immediately, without waiting for a clock edge.
- While Rst is high, busX = busY = 0 and busyX = busyY = 0; state stays cleared and WEN/RSV are ignored. Reset asserted mid-write or mid-reserve discards that operation.
- Write: at posedge Clk with WEN=1, reg[RW] <= busW and busy[RW] <= 0. If ZERO_REG=1 and RW=0, no effect.
- Reserve: at posedge Clk with RSV=1, busy[RR] <= 1. If ZERO_REG=1 and RR=0, no effect. Reserving an already-busy register leaves it busy; busy_cnt does not change.
- Write and reserve to the same address in the same cycle: reserve wins (a new producer has issued). Data is still written and busy ends at 1.
- Write and reserve to different addresses in the same cycle: both take effect.
- Read data, when not in reset:
  - If ZERO_REG=1 and address=0: returns 0.
  - Else if BYPASS=1, WEN=1 and RW equals the read address: returns busW.
  - Else: returns reg[address].
- Busy flags: busyX = busy[RX], busyY = busy[RY].
  - When BYPASS=1, WEN=1, RW equals the read address and RSV does not target that same address this cycle, the flag reads 0 (result available now).
  - r0 with ZERO_REG=1 always reads 0.
- busy_cnt: registered, equal to the number of set busy bits after each edge. Range 0..DEPTH, or 0..DEPTH-1 when ZERO_REG=1. Updated in the same edge as the busy bits; no wrap.
- Latency: write and reserve visible to reads the cycle after the edge, or the same cycle via bypass (BYPASS=1, write only).
- No X propagation: every output is defined from reset onward.

Test Plan:
- Reset: assert Rst mid-cycle with all registers written -> busX=busY=0, busy_cnt=0 before the next Clk edge; registers read 0 after release.
- Write/read: WEN=1, RW=6, busW=8'hAA, then RX=6, RY=7 -> busX=8'hAA, busY=8'h00. With BYPASS=1, busX=8'hAA already in the write cycle.
- Zero register: WEN=1, RW=0, busW=8'hFF; RSV=1, RR=0 -> busX(RX=0)=0, busyX=0, busy_cnt=0.
- Scoreboard: RSV on r3, then r5 -> busy_cnt=2, busyX(RX=3)=1. Write r3=8'h12 -> busyX=0, busy_cnt=1, busX=8'h12.
- Conflict: same cycle WEN=1, RW=4, busW=8'h55 and RSV=1, RR=4 -> next cycle busX(RX=4)=8'h55, busyX=1, busy_cnt incremented by 1.
- Parametrisation: DATA_W=16, ADDR_W=4 -> write 16'hBEEF to r15, read back 16'hBEEF. Reserve all 15 non-zero registers -> busy_cnt=15.
